// File: rtl/loader_pkg.sv
// loader_pkg: shared types and defaults for the UART program loader.
// The CHK state is only reached when LOADER_CHECKSUM_EN is defined.
package loader_pkg;
   localparam int MEM_WORDS = 128;
   localparam int ADDR_W = $clog2(MEM_WORDS);
   localparam int DEFAULT_CLKS_PER_BIT = 868;
   typedef enum logic [2:0] {HDR, DATA, WRITE, CHK, DONE} state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and start-glitch rejection.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = loader_pkg::DEFAULT_CLKS_PER_BIT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {IDLE, START, BITS, STOP} rx_state_t;
   rx_state_t state, state_n;
   logic [2:0] sync;
   logic [CW-1:0] cnt;
   logic [2:0] bit_idx;
   logic half, full;
   assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
   assign full = cnt == CW'(CLKS_PER_BIT - 1);
   // sync[1] is the synchronized line, sync[2] its previous value for edge detection
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = (sync[2] && !sync[1]) ? START : IDLE;
         START:   state_n = half ? (sync[1] ? IDLE : BITS) : START;
         BITS:    state_n = (full && bit_idx == 3'd7) ? STOP : BITS;
         STOP:    state_n = full ? IDLE : STOP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         sync       <= '1;
         cnt        <= '0;
         bit_idx    <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         sync       <= {sync[1:0], rx};
         cnt        <= (state == IDLE || state_n != state || full) ? '0 : cnt + 1'b1;
         bit_idx    <= (state == BITS && full) ? bit_idx + 1'b1 : bit_idx;
         data       <= (state == BITS && full) ? {sync[1], data[7:1]} : data;
         byte_valid <= state == STOP && full && sync[1];
         frame_err  <= state == STOP && full && !sync[1];
      end
   end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: loads a big-endian word image from UART into memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = loader_pkg::DEFAULT_CLKS_PER_BIT,
   parameter int MEM_WORDS    = loader_pkg::MEM_WORDS
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         bypass,
   input  logic                         rx,
   output logic                         mem_cs,
   output logic                         mem_we,
   output logic                         mem_drive,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   output logic [31:0]                  mem_wdata,
   output logic                         cpu_hold,
   output logic                         done,
   output logic                         err
);
   import loader_pkg::*;
   localparam int AW = $clog2(MEM_WORDS);
   localparam int IW = AW + 1;
   state_t state, state_n;
   logic [7:0] byte_data;
   logic byte_valid, frame_err, bv, fe, hdr, last, wr;
   logic [IW-1:0] count, widx;
   logic [1:0] bidx;
   logic [31:0] word;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif
   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) rx_i (
      .CLK(CLK), .RST(RST), .rx(rx), .data(byte_data), .byte_valid(byte_valid), .frame_err(frame_err)
   );
   assign bv   = byte_valid && !bypass;
   assign fe   = frame_err && !bypass;
   assign hdr  = bv && (state == HDR || state == DONE);
   assign last = widx + 1'b1 == count;
   assign wr   = state == WRITE && !bypass;
   assign mem_cs    = wr;
   assign mem_we    = wr;
   assign mem_drive = wr;
   assign mem_addr  = wr ? widx[AW-1:0] : '0;
   assign mem_wdata = wr ? word : '0;
   assign cpu_hold  = !bypass && state != DONE;
   always_comb begin
      state_n = state;
      if (bypass || fe)
         state_n = HDR;
      else
         case (state)
            HDR, DONE: state_n = bv ? DATA : state;
            DATA:      state_n = (bv && bidx == 2'd3) ? WRITE : DATA;
`ifdef LOADER_CHECKSUM_EN
            WRITE:     state_n = last ? CHK : DATA;
            CHK:       state_n = bv ? ((byte_data == csum) ? DONE : HDR) : CHK;
`else
            WRITE:     state_n = last ? DONE : DATA;
`endif
            default:   state_n = HDR;
         endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= HDR;
         count <= '0;
         widx  <= '0;
         bidx  <= '0;
         word  <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum  <= '0;
`endif
      end else begin
         state <= state_n;
         if (hdr) begin
            count <= (byte_data == 8'd0) ? IW'(MEM_WORDS) : IW'(byte_data);
            widx  <= '0;
            bidx  <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
         end
         if (state == DATA && bv) begin
            word <= {word[23:0], byte_data};
            bidx <= bidx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
         end
         if (state == WRITE) widx <= widx + 1'b1;
         if (state_n == DONE && state != DONE) done <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         if (fe || (state == CHK && bv && byte_data != csum)) err <= 1'b1;
`else
         if (fe) err <= 1'b1;
`endif
      end
   end
endmodule
